// File: rtl/traffic_light_ctrl_param.sv
// Two-road intersection controller with programmable dwell times, all-red
// clearance, latched pedestrian walk, NS rest-on-green and night flashing.
module traffic_light_ctrl_param #(
    parameter int TIMER_W       = 8,
    parameter int NS_GREEN_TIME = 30,
    parameter int EW_GREEN_TIME = 20,
    parameter int YELLOW_TIME   = 5,
    parameter int CLEAR_TIME    = 2,
    parameter int WALK_TIME     = 10,
    parameter int FLASH_HALF    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ew_sensor,
    input  logic               ped_req,
    input  logic               night_mode,
    output logic [2:0]         ns_light,
    output logic [2:0]         ew_light,
    output logic               walk,
    output logic               ped_wait,
    output logic [2:0]         phase,
    output logic [TIMER_W-1:0] timer_o
);

    // state     | meaning
    // NS_GREEN  | NS flowing; rests here (timer 0) until demand
    // NS_YELLOW | NS yellow
    // NS_CLEAR  | all-red after NS
    // EW_GREEN  | EW flowing, fixed dwell
    // EW_YELLOW | EW yellow
    // EW_CLEAR  | all-red after EW; picks FLASH / PED_WALK / NS_GREEN
    // PED_WALK  | all-red with WALK lamp lit
    // FLASH     | night flashing, NS yellow / EW red blinking
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        NS_CLEAR  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        EW_CLEAR  = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } state_t;

    localparam logic [TIMER_W-1:0] T_NS_GREEN = TIMER_W'(NS_GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] T_EW_GREEN = TIMER_W'(EW_GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] T_YELLOW   = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] T_CLEAR    = TIMER_W'(CLEAR_TIME - 1);
    localparam logic [TIMER_W-1:0] T_WALK     = TIMER_W'(WALK_TIME - 1);
    localparam logic [TIMER_W-1:0] T_FLASH    = TIMER_W'(FLASH_HALF - 1);

    localparam logic [2:0] LAMP_G    = 3'b001;
    localparam logic [2:0] LAMP_Y    = 3'b010;
    localparam logic [2:0] LAMP_R    = 3'b100;
    localparam logic [2:0] LAMP_DARK = 3'b000;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               ped_pending;
    logic               flash_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= NS_GREEN;
            timer       <= T_NS_GREEN;
            ped_pending <= 1'b0;
            flash_phase <= 1'b1;
        end else begin
            if (ped_req && state != PED_WALK)
                ped_pending <= 1'b1;

            if (timer != '0) begin
                timer <= timer - 1'b1;
            end else begin
                case (state)
                    NS_GREEN: begin
                        if (ew_sensor || ped_pending || night_mode) begin
                            state <= NS_YELLOW;
                            timer <= T_YELLOW;
                        end
                    end
                    NS_YELLOW: begin
                        state <= NS_CLEAR;
                        timer <= T_CLEAR;
                    end
                    NS_CLEAR: begin
                        if (night_mode) begin
                            state       <= FLASH;
                            timer       <= T_FLASH;
                            flash_phase <= 1'b1;
                        end else begin
                            state <= EW_GREEN;
                            timer <= T_EW_GREEN;
                        end
                    end
                    EW_GREEN: begin
                        state <= EW_YELLOW;
                        timer <= T_YELLOW;
                    end
                    EW_YELLOW: begin
                        state <= EW_CLEAR;
                        timer <= T_CLEAR;
                    end
                    EW_CLEAR: begin
                        if (night_mode) begin
                            state       <= FLASH;
                            timer       <= T_FLASH;
                            flash_phase <= 1'b1;
                        end else if (ped_pending) begin
                            // this later assignment overrides a same-cycle set
                            state       <= PED_WALK;
                            timer       <= T_WALK;
                            ped_pending <= 1'b0;
                        end else begin
                            state <= NS_GREEN;
                            timer <= T_NS_GREEN;
                        end
                    end
                    PED_WALK: begin
                        state <= NS_GREEN;
                        timer <= T_NS_GREEN;
                    end
                    FLASH: begin
                        if (!night_mode) begin
                            state <= EW_CLEAR;
                            timer <= T_CLEAR;
                        end else begin
                            timer       <= T_FLASH;
                            flash_phase <= ~flash_phase;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        ns_light = LAMP_R;
        ew_light = LAMP_R;
        case (state)
            NS_GREEN:  ns_light = LAMP_G;
            NS_YELLOW: ns_light = LAMP_Y;
            EW_GREEN:  ew_light = LAMP_G;
            EW_YELLOW: ew_light = LAMP_Y;
            FLASH: begin
                ns_light = flash_phase ? LAMP_Y : LAMP_DARK;
                ew_light = flash_phase ? LAMP_R : LAMP_DARK;
            end
            default: begin
                ns_light = LAMP_R;
                ew_light = LAMP_R;
            end
        endcase
    end

    assign walk     = (state == PED_WALK);
    assign ped_wait = ped_pending;
    assign phase    = state;
    assign timer_o  = timer;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Bench for traffic_light_ctrl_param: directed vector table, hand sequences
// and randomized stimulus against a phase/elapsed-time reference model.
module tb_traffic_light_ctrl_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ew_sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic [2:0] ns_light, ew_light;
    logic       walk, ped_wait;
    logic [2:0] phase;
    logic [7:0] timer_o;

    traffic_light_ctrl_param #(
        .TIMER_W(8), .NS_GREEN_TIME(30), .EW_GREEN_TIME(20), .YELLOW_TIME(5),
        .CLEAR_TIME(2), .WALK_TIME(10), .FLASH_HALF(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ew_sensor(ew_sensor), .ped_req(ped_req),
        .night_mode(night_mode), .ns_light(ns_light), .ew_light(ew_light),
        .walk(walk), .ped_wait(ped_wait), .phase(phase), .timer_o(timer_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: current phase, cycles spent in it, pedestrian latch, flash lamp state
    int dur [8] = '{30, 5, 2, 20, 5, 2, 10, 1};
    int m_phase, m_elapsed;
    bit m_ped, m_flash;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0; m_elapsed = 0; m_ped = 0; m_flash = 1;
    endfunction

    function automatic void model_step(input bit ew, input bit ped, input bit night);
        int nxt = m_phase;
        bit reload = 0;
        if (m_elapsed >= dur[m_phase] - 1) begin
            case (m_phase)
                0: if (ew || m_ped || night) nxt = 1;
                1: nxt = 2;
                2: nxt = night ? 7 : 3;
                3: nxt = 4;
                4: nxt = 5;
                5: nxt = night ? 7 : (m_ped ? 6 : 0);
                6: nxt = 0;
                default: if (!night) nxt = 5; else begin reload = 1; m_flash = !m_flash; end
            endcase
        end
        if (nxt == 6 && m_phase != 6) m_ped = 0;
        else if (ped && m_phase != 6) m_ped = 1;
        if (nxt == 7 && m_phase != 7) m_flash = 1;
        if (nxt != m_phase || reload) m_elapsed = 0; else m_elapsed++;
        m_phase = nxt;
    endfunction

    function automatic int exp_timer();
        int e = dur[m_phase] - 1 - m_elapsed;
        return (e < 0) ? 0 : e;
    endfunction

    function automatic int exp_ns();
        case (m_phase)
            0: return 1;
            1: return 2;
            7: return m_flash ? 2 : 0;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_ew();
        case (m_phase)
            3: return 1;
            4: return 2;
            7: return m_flash ? 4 : 0;
            default: return 4;
        endcase
    endfunction

    task automatic check_model();
        bit ns_go, ew_go;
        chk("phase", phase, m_phase);
        chk("timer_o", timer_o, exp_timer());
        chk("ns_light", ns_light, exp_ns());
        chk("ew_light", ew_light, exp_ew());
        chk("walk", walk, (m_phase == 6) ? 1 : 0);
        chk("ped_wait", ped_wait, m_ped);
        ns_go = (ns_light == 3'b001) || (ns_light == 3'b010);
        ew_go = (ew_light == 3'b001) || (ew_light == 3'b010);
        chk("safety", ns_go && ew_go, 0);
    endtask

    // called at negedge; returns at the following negedge with outputs checked
    task automatic tick(input bit ew, input bit ped, input bit night);
        ew_sensor = ew; ped_req = ped; night_mode = night;
        @(posedge clk);
        if (rst_n) model_step(ew, ped, night);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        ew_sensor = 0; ped_req = 0; night_mode = 0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        check_model();
        chk("rst_ns", ns_light, 3'b001);
        chk("rst_ew", ew_light, 3'b100);
        chk("rst_phase", phase, 0);
        chk("rst_timer", timer_o, 29);
        rst_n = 1;
    endtask

    typedef struct {
        int n;
        bit ew, ped, night;
        int ph, tm;
        logic [2:0] ns, ewl;
        bit wk, pw;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int walk_cycles, walk_entries, pw_in_walk, pw74, pw75;
        bit prev_walk, ew_r, night_r;

        vecs.push_back(vec_t'{1,  1,0,0, 0,28, 3'b001,3'b100, 0,0});
        vecs.push_back(vec_t'{28, 1,0,0, 0,0,  3'b001,3'b100, 0,0});
        vecs.push_back(vec_t'{1,  1,0,0, 1,4,  3'b010,3'b100, 0,0});
        vecs.push_back(vec_t'{5,  1,0,0, 2,1,  3'b100,3'b100, 0,0});
        vecs.push_back(vec_t'{2,  1,0,0, 3,19, 3'b100,3'b001, 0,0});
        vecs.push_back(vec_t'{20, 1,0,0, 4,4,  3'b100,3'b010, 0,0});
        vecs.push_back(vec_t'{5,  1,0,0, 5,1,  3'b100,3'b100, 0,0});
        vecs.push_back(vec_t'{2,  1,0,0, 0,29, 3'b001,3'b100, 0,0});
        vecs.push_back(vec_t'{29, 0,0,0, 0,0,  3'b001,3'b100, 0,0});
        vecs.push_back(vec_t'{50, 0,0,0, 0,0,  3'b001,3'b100, 0,0});
        vecs.push_back(vec_t'{1,  1,1,0, 1,4,  3'b010,3'b100, 0,1});
        vecs.push_back(vec_t'{5,  1,0,0, 2,1,  3'b100,3'b100, 0,1});
        vecs.push_back(vec_t'{2,  1,0,0, 3,19, 3'b100,3'b001, 0,1});
        vecs.push_back(vec_t'{20, 1,0,0, 4,4,  3'b100,3'b010, 0,1});
        vecs.push_back(vec_t'{5,  1,0,0, 5,1,  3'b100,3'b100, 0,1});
        vecs.push_back(vec_t'{2,  1,0,0, 6,9,  3'b100,3'b100, 1,0});
        vecs.push_back(vec_t'{10, 1,0,0, 0,29, 3'b001,3'b100, 0,0});
        vecs.push_back(vec_t'{29, 0,0,1, 0,0,  3'b001,3'b100, 0,0});
        vecs.push_back(vec_t'{1,  0,0,1, 1,4,  3'b010,3'b100, 0,0});
        vecs.push_back(vec_t'{5,  0,0,1, 2,1,  3'b100,3'b100, 0,0});
        vecs.push_back(vec_t'{2,  0,0,1, 7,0,  3'b010,3'b100, 0,0});
        vecs.push_back(vec_t'{1,  0,0,1, 7,0,  3'b000,3'b000, 0,0});
        vecs.push_back(vec_t'{1,  0,0,1, 7,0,  3'b010,3'b100, 0,0});
        vecs.push_back(vec_t'{1,  0,0,0, 5,1,  3'b100,3'b100, 0,0});
        vecs.push_back(vec_t'{2,  0,0,0, 0,29, 3'b001,3'b100, 0,0});

        @(negedge clk);
        do_reset();

        // directed table
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].ew, vecs[i].ped, vecs[i].night);
            chk($sformatf("vec%0d_phase", i), phase, vecs[i].ph);
            chk($sformatf("vec%0d_timer", i), timer_o, vecs[i].tm);
            chk($sformatf("vec%0d_ns", i), ns_light, vecs[i].ns);
            chk($sformatf("vec%0d_ew", i), ew_light, vecs[i].ewl);
            chk($sformatf("vec%0d_walk", i), walk, vecs[i].wk);
            chk($sformatf("vec%0d_pedwait", i), ped_wait, vecs[i].pw);
        end

        // ped_req held through two full rounds
        do_reset();
        walk_cycles = 0; walk_entries = 0; pw_in_walk = 0; pw74 = -1; pw75 = -1;
        prev_walk = 0;
        for (int i = 1; i <= 148; i++) begin
            tick(1, 1, 0);
            if (walk) begin
                walk_cycles++;
                if (!prev_walk) walk_entries++;
                if (ped_wait) pw_in_walk++;
            end
            prev_walk = walk;
            if (i == 74) pw74 = ped_wait;
            if (i == 75) pw75 = ped_wait;
        end
        chk("held_walk_cycles", walk_cycles, 20);
        chk("held_walk_entries", walk_entries, 2);
        chk("held_pedwait_in_walk", pw_in_walk, 0);
        chk("held_pedwait_after_walk", pw74, 0);
        chk("held_pedwait_relatch", pw75, 1);

        // asynchronous reset in the middle of EW_GREEN
        do_reset();
        for (int i = 0; i < 45; i++) tick(1, 0, 0);
        chk("pre_async_phase", phase, 3);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("async_ns", ns_light, 3'b001);
        chk("async_ew", ew_light, 3'b100);
        chk("async_phase", phase, 0);
        chk("async_timer", timer_o, 29);
        model_reset();
        @(negedge clk);
        check_model();
        rst_n = 1;
        tick(1, 0, 0);
        chk("post_async_timer", timer_o, 28);

        // randomized stimulus against the model
        do_reset();
        ew_r = 0; night_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) ew_r = !ew_r;
            if ($urandom_range(0, 299) == 0) night_r = !night_r;
            tick(ew_r, ($urandom_range(0, 39) == 0), night_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
